// File: rtl/fmap_pingpong_ram.sv
// fmap_pingpong_ram: two-bank ping-pong feature-map buffer. The writer fills one bank while
// the reader randomly addresses the other, committed bank. Ownership moves by commit/release.
module fmap_pingpong_ram #(
  parameter int CH    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CH*DW-1:0] wr_data,
  input  logic             wr_commit,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH*DW-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_release,
  output logic             rd_frame_valid,
  output logic             err_wr,
  output logic             err_rd
);

  localparam int WW = CH * DW;
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WW-1:0] mem [2][DEPTH];

  logic [1:0] full;
  logic [1:0] full_next;
  logic       wr_sel;
  logic       wr_sel_next;
  logic       rd_sel;
  logic       rd_sel_next;
  logic       err_wr_next;
  logic       err_rd_next;

  logic wr_addr_ok;
  logic rd_addr_ok;
  logic wr_acc;
  logic commit_acc;
  logic rd_acc;
  logic release_acc;

  assign wr_ready       = ~full[wr_sel];
  assign rd_frame_valid = full[rd_sel];

  // Addresses are compared one bit wider so DEPTH = 2^AW is still representable.
  assign wr_addr_ok  = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_addr_ok  = ({1'b0, rd_addr} < DEPTH_LIM);

  assign wr_acc      = wr_en & wr_ready & wr_addr_ok;
  assign commit_acc  = wr_commit & wr_ready;
  assign rd_acc      = rd_en & rd_frame_valid & rd_addr_ok;
  assign release_acc = rd_release & rd_frame_valid;

  // A commit targets an empty bank and a release a full one, so when both fire they never collide.
  always_comb begin
    full_next   = full;
    wr_sel_next = wr_sel;
    rd_sel_next = rd_sel;
    err_wr_next = err_wr;
    err_rd_next = err_rd;
    if (commit_acc) begin
      full_next[wr_sel] = 1'b1;
      wr_sel_next       = ~wr_sel;
    end
    if (release_acc) begin
      full_next[rd_sel] = 1'b0;
      rd_sel_next       = ~rd_sel;
    end
    if ((wr_en && !(wr_ready && wr_addr_ok)) || (wr_commit && !wr_ready)) begin
      err_wr_next = 1'b1;
    end
    if ((rd_en && !rd_acc) || (rd_release && !rd_frame_valid)) begin
      err_rd_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      full   <= full_next;
      wr_sel <= wr_sel_next;
      rd_sel <= rd_sel_next;
      err_wr <= err_wr_next;
      err_rd <= err_rd_next;
    end
  end

  // RAM array carries no reset so it maps onto block memory; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_sel][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_sel][rd_addr];
      end
    end
  end

endmodule
